ped_crossing_ctrl: RTL and testbench

Demand-driven scheduler for a single pedestrian crossing on one road. It arbitrates the shared crossing between road traffic and a debounced pedestrian push-button, and sequences the road lamps (green/yellow/red) and pedestrian lamps (green/red) with a guaranteed minimum road green. It replaces the free-running fixed cycle at the board top level, driving the same five lamp pins plus a "wait" indicator.

---
 rtl/ped_crossing_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Demand-driven pedestrian crossing scheduler: debounced button, request latch, six-phase lamp sequencer.
// Optional PED_FLASH_EN: pedestrian green flashes at 1 Hz during the clearance phase.
module ped_crossing_ctrl #(
  parameter int TIMER_SCALE     = 16000000,
  parameter int MIN_GREEN_S     = 10,
  parameter int YELLOW_S        = 3,
  parameter int ALLRED_S        = 2,
  parameter int PED_WALK_S      = 8,
  parameter int PED_CLEAR_S     = 4,
  parameter int DEBOUNCE_CYCLES = 160000
) (
  input  logic pin3_clk_16mhz,
  input  logic rst,
  input  logic pin9_ped_button,
  output logic pin4_green,
  output logic pin5_yellow,
  output logic pin6_red,
  output logic pin7_ped_green,
  output logic pin8_ped_red,
  output logic pin10_wait
);

  typedef enum logic [2:0] {
    ALL_RED_B   = 3'd0,
    ROAD_GREEN  = 3'd1,
    ROAD_YELLOW = 3'd2,
    ALL_RED_A   = 3'd3,
    PED_WALK    = 3'd4,
    PED_CLEAR   = 3'd5
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_S = max2(max2(max2(MIN_GREEN_S, YELLOW_S), max2(ALLRED_S, PED_WALK_S)), PED_CLEAR_S);
  localparam int SEC_W = $clog2(MAX_S + 1);
  localparam int PRE_W = (TIMER_SCALE > 1) ? $clog2(TIMER_SCALE) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TIMER_SCALE - 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEC_W-1:0] GREEN_MIN   = SEC_W'(MIN_GREEN_S);
  localparam logic [SEC_W-1:0] YELLOW_LAST = SEC_W'(YELLOW_S - 1);
  localparam logic [SEC_W-1:0] ALLRED_LAST = SEC_W'(ALLRED_S - 1);
  localparam logic [SEC_W-1:0] WALK_LAST   = SEC_W'(PED_WALK_S - 1);
  localparam logic [SEC_W-1:0] CLEAR_LAST  = SEC_W'(PED_CLEAR_S - 1);
`ifdef PED_FLASH_EN
  localparam logic [PRE_W-1:0] PRE_HALF    = PRE_W'(TIMER_SCALE / 2);
`endif

  logic             sync1_r, sync2_r, stable_r, stable_d_r;
  logic [DB_W-1:0]  db_cnt_r;
  logic             press_s;
  state_t           state_r, state_nxt_s;
  logic [PRE_W-1:0] prescaler_r, prescaler_nxt_s;
  logic [SEC_W-1:0] sec_cnt_r, sec_cnt_nxt_s;
  logic             tick_s;
  logic             req_q_r, req_nxt_s;
  logic             green_r, yellow_r, red_r, ped_green_r, ped_red_r;
  logic             green_s, yellow_s, red_s, ped_green_s, ped_red_s;

  assign press_s = stable_r & ~stable_d_r;
  assign tick_s  = (prescaler_r == PRE_LAST);

  // Button synchronizer and debouncer; a flip needs DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge pin3_clk_16mhz or posedge rst) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      db_cnt_r   <= '0;
    end else begin
      sync1_r    <= pin9_ped_button;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      if (sync2_r == stable_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
        stable_r <= ~stable_r;
        db_cnt_r <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + 1'b1;
      end
    end
  end

  // Phase sequencing; road green holds until both the minimum green and a request are present.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ALL_RED_B:   if (tick_s && sec_cnt_r == ALLRED_LAST) state_nxt_s = ROAD_GREEN;  else state_nxt_s = ALL_RED_B;
      ROAD_GREEN:  if (sec_cnt_r == GREEN_MIN && req_q_r)  state_nxt_s = ROAD_YELLOW; else state_nxt_s = ROAD_GREEN;
      ROAD_YELLOW: if (tick_s && sec_cnt_r == YELLOW_LAST) state_nxt_s = ALL_RED_A;   else state_nxt_s = ROAD_YELLOW;
      ALL_RED_A:   if (tick_s && sec_cnt_r == ALLRED_LAST) state_nxt_s = PED_WALK;    else state_nxt_s = ALL_RED_A;
      PED_WALK:    if (tick_s && sec_cnt_r == WALK_LAST)   state_nxt_s = PED_CLEAR;   else state_nxt_s = PED_WALK;
      PED_CLEAR:   if (tick_s && sec_cnt_r == CLEAR_LAST)  state_nxt_s = ALL_RED_B;   else state_nxt_s = PED_CLEAR;
      default:     state_nxt_s = ALL_RED_B;
    endcase
  end

  // Timers restart on every phase change; green's second counter saturates at the minimum.
  always_comb begin
    prescaler_nxt_s = prescaler_r;
    sec_cnt_nxt_s   = sec_cnt_r;
    if (state_nxt_s != state_r) begin
      prescaler_nxt_s = '0;
      sec_cnt_nxt_s   = '0;
    end else begin
      if (tick_s) begin
        prescaler_nxt_s = '0;
      end else begin
        prescaler_nxt_s = prescaler_r + 1'b1;
      end
      if (tick_s && !(state_r == ROAD_GREEN && sec_cnt_r == GREEN_MIN)) begin
        sec_cnt_nxt_s = sec_cnt_r + 1'b1;
      end else begin
        sec_cnt_nxt_s = sec_cnt_r;
      end
    end
  end

  // Request latch: entering the walk clears it even against a simultaneous press.
  always_comb begin
    req_nxt_s = req_q_r;
    if (state_nxt_s == PED_WALK && state_r != PED_WALK) begin
      req_nxt_s = 1'b0;
    end else if (press_s && state_r != PED_WALK) begin
      req_nxt_s = 1'b1;
    end else begin
      req_nxt_s = req_q_r;
    end
  end

  // Lamp decode from the next state so lamps switch on the same edge as the state.
  always_comb begin
    green_s     = 1'b0;
    yellow_s    = 1'b0;
    red_s       = 1'b1;
    ped_green_s = 1'b0;
    ped_red_s   = 1'b1;
    case (state_nxt_s)
      ROAD_GREEN:  begin green_s  = 1'b1; red_s = 1'b0; end
      ROAD_YELLOW: begin yellow_s = 1'b1; red_s = 1'b0; end
      PED_WALK:    begin ped_green_s = 1'b1; ped_red_s = 1'b0; end
      PED_CLEAR: begin
`ifdef PED_FLASH_EN
        ped_red_s = 1'b0;
        if (prescaler_nxt_s < PRE_HALF) begin
          ped_green_s = 1'b1;
        end else begin
          ped_green_s = 1'b0;
        end
`else
        ped_green_s = 1'b0;
        ped_red_s   = 1'b1;
`endif
      end
      ALL_RED_A, ALL_RED_B: begin red_s = 1'b1; ped_red_s = 1'b1; end
      default: begin red_s = 1'b1; ped_red_s = 1'b1; end
    endcase
  end

  // State, timer, request and lamp registers.
  always_ff @(posedge pin3_clk_16mhz or posedge rst) begin
    if (rst) begin
      state_r     <= ALL_RED_B;
      prescaler_r <= '0;
      sec_cnt_r   <= '0;
      req_q_r     <= 1'b0;
      green_r     <= 1'b0;
      yellow_r    <= 1'b0;
      red_r       <= 1'b1;
      ped_green_r <= 1'b0;
      ped_red_r   <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      prescaler_r <= prescaler_nxt_s;
      sec_cnt_r   <= sec_cnt_nxt_s;
      req_q_r     <= req_nxt_s;
      green_r     <= green_s;
      yellow_r    <= yellow_s;
      red_r       <= red_s;
      ped_green_r <= ped_green_s;
      ped_red_r   <= ped_red_s;
    end
  end

  assign pin4_green     = green_r;
  assign pin5_yellow    = yellow_r;
  assign pin6_red       = red_r;
  assign pin7_ped_green = ped_green_r;
  assign pin8_ped_red   = ped_red_r;
  assign pin10_wait     = req_q_r;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scoreboard bench for ped_crossing_ctrl: each output-vector change is popped against a queued
// {lamps+wait, cycles since previous change} expectation. Vector order: {green,yellow,red,ped_green,ped_red,wait}.
module tb_ped_crossing_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic g, y, r, pg, pr, w;

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [5:0] vec;
    int         delta;
  } exp_t;
  exp_t sb_q[$];

  ped_crossing_ctrl #(
    .TIMER_SCALE(4), .MIN_GREEN_S(3), .YELLOW_S(2), .ALLRED_S(1),
    .PED_WALK_S(3), .PED_CLEAR_S(2), .DEBOUNCE_CYCLES(3)
  ) dut (
    .pin3_clk_16mhz(clk), .rst(rst), .pin9_ped_button(btn),
    .pin4_green(g), .pin5_yellow(y), .pin6_red(r),
    .pin7_ped_green(pg), .pin8_ped_red(pr), .pin10_wait(w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic [5:0] v, input int d);
    exp_t e;
    e.vec = v;
    e.delta = d;
    sb_q.push_back(e);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press(input int t0, input int len);
    at_cyc(t0);
    btn = 1'b1;
    at_cyc(t0 + len);
    btn = 1'b0;
  endtask

  // Monitor: every change of the sampled output vector consumes one scoreboard entry.
  initial begin : monitor
    logic [5:0] prev_vec;
    logic [5:0] vec;
    int last_change;
    exp_t e;
    prev_vec = 6'b001010;
    last_change = 3;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        vec = {g, y, r, pg, pr, w};
        if (vec !== prev_vec) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_change", {26'd0, vec}, {26'd0, prev_vec});
          end else begin
            e = sb_q.pop_front();
            chk("lamp_vec", {26'd0, vec}, {26'd0, e.vec});
            chk("delta_cycles", cyc - last_change, e.delta);
          end
          prev_vec = vec;
          last_change = cyc;
        end
      end
    end
  end

  initial begin : stimulus
    // Reset state, then release and expect green after one all-red second.
    at_cyc(3);
    #1 chk("reset_vec", {26'd0, g, y, r, pg, pr, w}, 32'h0A);
    push(6'b100010, 4);
    rst = 1'b0;
    mon_en = 1'b1;

    // Bounces of one and two cycles must not register.
    press(50, 1);
    press(70, 2);
    at_cyc(100);
    #1 chk("bounce_no_wait", {31'd0, w}, 32'd0);
    chk("bounce_still_green", {31'd0, g}, 32'd1);

    // Crossing 1: press long after min green; a press during walk is ignored.
    push(6'b100011, 209);
    push(6'b010011, 1);
    push(6'b001011, 8);
    push(6'b001100, 4);
`ifdef PED_FLASH_EN
    push(6'b001100, 12); push(6'b001000, 2); push(6'b001100, 2); push(6'b001000, 2);
    push(6'b001010, 2);  push(6'b100010, 4);
`else
    push(6'b001010, 12); push(6'b100010, 12);
`endif
    press(210, 10);
    press(231, 10);
    at_cyc(245);
    #1 chk("walk_press_ignored", {31'd0, w}, 32'd0);

    // Crossing 2: press at green cycle 2, then a press during clearance for crossing 3.
    push(6'b100011, 8);
    push(6'b010011, 5);
    push(6'b001011, 8);
    push(6'b001100, 4);
`ifdef PED_FLASH_EN
    push(6'b001100, 12); push(6'b001000, 2); push(6'b001100, 2); push(6'b001000, 2);
    push(6'b001001, 1);  push(6'b001011, 1); push(6'b100011, 4);
`else
    push(6'b001010, 12); push(6'b001011, 7); push(6'b100011, 5);
`endif
    push(6'b010011, 13);
    push(6'b001011, 8);
    push(6'b001100, 4);
    press(255, 10);
    press(291, 10);

    // Reset during walk: lamps go all-red at once, request lost, normal restart.
    push(6'b001010, 6);
    push(6'b100010, 7);
    at_cyc(332);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_midwalk_vec", {26'd0, g, y, r, pg, pr, w}, 32'h0A);
    at_cyc(336);
    rst = 1'b0;
    at_cyc(400);
    #1 chk("after_rst_green", {26'd0, g, y, r, pg, pr, w}, 32'h22);

    at_cyc(420);
    #1 chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
